// File: rtl/csr_wr_pipe.sv
// csr_wr_pipe: carries CSR write intent EX->MM1->MM2->WB and commits soft-interrupt fields of ECFG.LIE / ESTAT.IS.
// Optional build macro CSR_HWI_EN adds hw_int sampling into ESTAT.IS[9:2] and widens LIE to 10 bits.
module csr_wr_pipe #(
    parameter logic [13:0] CSR_ECFG_ADDR  = 14'h4,
    parameter logic [13:0] CSR_ESTAT_ADDR = 14'h5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [13:0] ex_csr_addr,
    input  logic        ex_csr_we,
    input  logic [31:0] ex_csr_wdata,
    input  logic [31:0] ex_csr_wmask,
    output logic        ex_allowin,
    input  logic        wb_stall,
    input  logic        flush,
`ifdef CSR_HWI_EN
    input  logic [7:0]  hw_int,
    output logic [7:0]  csr_ecfg_lie_hw,
`endif
    output logic [13:0] mm1_csr_addr,
    output logic [13:0] mm2_csr_addr,
    output logic [13:0] wb_csr_addr,
    output logic        mm1_csr_we,
    output logic        mm2_csr_we,
    output logic        wb_csr_we,
    output logic [31:0] mm1_csr_wdata,
    output logic [31:0] mm2_csr_wdata,
    output logic [31:0] wb_csr_wdata,
    output logic [31:0] mm1_csr_wmask,
    output logic [31:0] mm2_csr_wmask,
    output logic [31:0] wb_csr_wmask,
    output logic [1:0]  csr_ecfg_lie_soft,
    output logic [1:0]  csr_estat_is_soft,
    output logic        soft_int_pending
);
`ifdef CSR_HWI_EN
    localparam int LW = 10;
`else
    localparam int LW = 2;
`endif

    logic          r_mm1_valid, r_mm2_valid, r_wb_valid;
    logic [13:0]   r_mm1_addr, r_mm2_addr, r_wb_addr;
    logic          r_mm1_we, r_mm2_we, r_wb_we;
    logic [31:0]   r_mm1_wdata, r_mm2_wdata, r_wb_wdata;
    logic [31:0]   r_mm1_wmask, r_mm2_wmask, r_wb_wmask;
    logic [LW-1:0] r_lie, r_is, w_lie_nxt, w_is_nxt;
    logic [1:0]    w_is_soft_nxt;
    logic          r_pend;
    logic          w_wb_allowin, w_mm2_allowin, w_mm1_allowin;
    logic          w_mm2_load, w_wb_load, w_commit;

    assign w_wb_allowin  = !r_wb_valid | !wb_stall;
    assign w_mm2_allowin = !r_mm2_valid | w_wb_allowin;
    assign w_mm1_allowin = !r_mm1_valid | w_mm2_allowin;
    assign ex_allowin    = w_mm1_allowin & !flush;
    assign w_mm2_load    = r_mm1_valid & w_mm2_allowin & !flush;
    assign w_wb_load     = r_mm2_valid & w_wb_allowin & !flush;
    assign w_commit      = r_wb_valid & !wb_stall & !flush & r_wb_we;

    // Next-state LIE/IS: masked merge of the retiring write into the addressed CSR field
    always_comb begin
        w_lie_nxt = (w_commit && r_wb_addr == CSR_ECFG_ADDR)
                  ? (r_lie & ~r_wb_wmask[LW-1:0]) | (r_wb_wdata[LW-1:0] & r_wb_wmask[LW-1:0]) : r_lie;
        w_is_soft_nxt = (w_commit && r_wb_addr == CSR_ESTAT_ADDR)
                      ? (r_is[1:0] & ~r_wb_wmask[1:0]) | (r_wb_wdata[1:0] & r_wb_wmask[1:0]) : r_is[1:0];
`ifdef CSR_HWI_EN
        w_is_nxt = {hw_int, w_is_soft_nxt};
`else
        w_is_nxt = w_is_soft_nxt;
`endif
    end

    // MM1 stage: accepts from EX unless flushed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mm1_valid <= 1'b0;
            r_mm1_addr  <= '0;
            r_mm1_we    <= 1'b0;
            r_mm1_wdata <= '0;
            r_mm1_wmask <= '0;
        end else begin
            r_mm1_valid <= flush ? 1'b0 : (w_mm1_allowin ? ex_valid : r_mm1_valid);
            if (ex_valid && ex_allowin) begin
                r_mm1_addr  <= ex_csr_addr;
                r_mm1_we    <= ex_csr_we;
                r_mm1_wdata <= ex_csr_wdata;
                r_mm1_wmask <= ex_csr_wmask;
            end
        end
    end

    // MM2 stage: accepts from MM1 when WB side can make room
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mm2_valid <= 1'b0;
            r_mm2_addr  <= '0;
            r_mm2_we    <= 1'b0;
            r_mm2_wdata <= '0;
            r_mm2_wmask <= '0;
        end else begin
            r_mm2_valid <= flush ? 1'b0 : (w_mm2_allowin ? r_mm1_valid : r_mm2_valid);
            if (w_mm2_load) begin
                r_mm2_addr  <= r_mm1_addr;
                r_mm2_we    <= r_mm1_we;
                r_mm2_wdata <= r_mm1_wdata;
                r_mm2_wmask <= r_mm1_wmask;
            end
        end
    end

    // WB stage: holds while stalled, cleared by flush even when stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_we    <= 1'b0;
            r_wb_wdata <= '0;
            r_wb_wmask <= '0;
        end else begin
            r_wb_valid <= flush ? 1'b0 : (w_wb_allowin ? r_mm2_valid : r_wb_valid);
            if (w_wb_load) begin
                r_wb_addr  <= r_mm2_addr;
                r_wb_we    <= r_mm2_we;
                r_wb_wdata <= r_mm2_wdata;
                r_wb_wmask <= r_mm2_wmask;
            end
        end
    end

    // Committed CSR fields and pending flag, pending taken from next state so both move together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lie  <= '0;
            r_is   <= '0;
            r_pend <= 1'b0;
        end else begin
            r_lie  <= w_lie_nxt;
            r_is   <= w_is_nxt;
            r_pend <= |(w_lie_nxt & w_is_nxt);
        end
    end

    assign mm1_csr_addr      = r_mm1_addr;
    assign mm2_csr_addr      = r_mm2_addr;
    assign wb_csr_addr       = r_wb_addr;
    assign mm1_csr_we        = r_mm1_we & r_mm1_valid;
    assign mm2_csr_we        = r_mm2_we & r_mm2_valid;
    assign wb_csr_we         = r_wb_we & r_wb_valid;
    assign mm1_csr_wdata     = r_mm1_wdata;
    assign mm2_csr_wdata     = r_mm2_wdata;
    assign wb_csr_wdata      = r_wb_wdata;
    assign mm1_csr_wmask     = r_mm1_wmask;
    assign mm2_csr_wmask     = r_mm2_wmask;
    assign wb_csr_wmask      = r_wb_wmask;
    assign csr_ecfg_lie_soft = r_lie[1:0];
    assign csr_estat_is_soft = r_is[1:0];
    assign soft_int_pending  = r_pend;
`ifdef CSR_HWI_EN
    assign csr_ecfg_lie_hw   = r_lie[9:2];
`endif
endmodule

// File: tb/tb_csr_wr_pipe.sv
// tb_csr_wr_pipe: directed plan checks plus randomized run against a queue-level reference model.
module tb_csr_wr_pipe;
    logic        clk, reset, ex_valid, ex_csr_we, wb_stall, flush, ex_allowin;
    logic [13:0] ex_csr_addr, mm1_csr_addr, mm2_csr_addr, wb_csr_addr;
    logic [31:0] ex_csr_wdata, ex_csr_wmask;
    logic        mm1_csr_we, mm2_csr_we, wb_csr_we;
    logic [31:0] mm1_csr_wdata, mm2_csr_wdata, wb_csr_wdata;
    logic [31:0] mm1_csr_wmask, mm2_csr_wmask, wb_csr_wmask;
    logic [1:0]  csr_ecfg_lie_soft, csr_estat_is_soft;
    logic        soft_int_pending;
`ifdef CSR_HWI_EN
    logic [7:0]  hw_int, csr_ecfg_lie_hw;
    localparam logic [9:0] LIE_MASK = 10'h3FF;
`else
    localparam logic [9:0] LIE_MASK = 10'h003;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        v;
        logic [13:0] a;
        logic        we;
        logic [31:0] d;
        logic [31:0] m;
    } slot_t;
    slot_t s [3];
    slot_t n [3];
    logic [9:0] m_lie, m_is;
    logic       m_pend;

    csr_wr_pipe dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_csr_addr(ex_csr_addr),
        .ex_csr_we(ex_csr_we), .ex_csr_wdata(ex_csr_wdata), .ex_csr_wmask(ex_csr_wmask),
        .ex_allowin(ex_allowin), .wb_stall(wb_stall), .flush(flush),
`ifdef CSR_HWI_EN
        .hw_int(hw_int), .csr_ecfg_lie_hw(csr_ecfg_lie_hw),
`endif
        .mm1_csr_addr(mm1_csr_addr), .mm2_csr_addr(mm2_csr_addr), .wb_csr_addr(wb_csr_addr),
        .mm1_csr_we(mm1_csr_we), .mm2_csr_we(mm2_csr_we), .wb_csr_we(wb_csr_we),
        .mm1_csr_wdata(mm1_csr_wdata), .mm2_csr_wdata(mm2_csr_wdata), .wb_csr_wdata(wb_csr_wdata),
        .mm1_csr_wmask(mm1_csr_wmask), .mm2_csr_wmask(mm2_csr_wmask), .wb_csr_wmask(wb_csr_wmask),
        .csr_ecfg_lie_soft(csr_ecfg_lie_soft), .csr_estat_is_soft(csr_estat_is_soft),
        .soft_int_pending(soft_int_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        ex_valid = 1'b1; ex_csr_addr = a; ex_csr_we = 1'b1; ex_csr_wdata = d; ex_csr_wmask = m;
    endtask

    // Reference: pipeline as an ordered list of three slots; entries slide toward WB
    // whenever the slot ahead is empty or is vacating, WB vacates unless stalled.
    function automatic void model_step();
        logic room;
        slot_t src;
        if (s[2].v && !wb_stall && !flush && s[2].we) begin
            if (s[2].a == 14'h4) m_lie = ((m_lie & ~s[2].m[9:0]) | (s[2].d[9:0] & s[2].m[9:0])) & LIE_MASK;
            if (s[2].a == 14'h5) m_is[1:0] = (m_is[1:0] & ~s[2].m[1:0]) | (s[2].d[1:0] & s[2].m[1:0]);
        end
`ifdef CSR_HWI_EN
        m_is[9:2] = hw_int;
`endif
        m_pend = |(m_lie & m_is);
        n = s;
        if (flush) begin
            for (int k = 0; k < 3; k++) n[k].v = 1'b0;
        end else begin
            room = !(s[2].v && wb_stall);
            for (int k = 2; k >= 0; k--) begin
                src = (k == 0) ? slot_t'{ex_valid, ex_csr_addr, ex_csr_we, ex_csr_wdata, ex_csr_wmask} : s[k-1];
                if (room) n[k] = src;
                room = room || !s[k].v;
                if (k > 0) room = room || !s[k-1].v;
                if (k > 0) room = !s[k-1].v || (room && (n[k] == s[k-1] || !s[k].v || room));
            end
        end
        s = n;
    endfunction

    initial begin
        logic [13:0] addrs [3];
        logic        exp_allow;
        addrs[0] = 14'h4; addrs[1] = 14'h5; addrs[2] = 14'h9;
        reset = 1'b1; ex_valid = 1'b0; ex_csr_addr = '0; ex_csr_we = 1'b0;
        ex_csr_wdata = '0; ex_csr_wmask = '0; wb_stall = 1'b0; flush = 1'b0;
`ifdef CSR_HWI_EN
        hw_int = '0;
`endif
        #12 reset = 1'b0;
        tick();
        chk("rst_allowin", ex_allowin, 1);
        chk("rst_wb_we", wb_csr_we, 0);
        chk("rst_lie", csr_ecfg_lie_soft, 0);
        chk("rst_pend", soft_int_pending, 0);

        set_ex(14'h4, 32'h3, 32'hFFFF_FFFF);
        tick(); ex_valid = 1'b0;
        chk("w1_mm1_we", mm1_csr_we, 1);
        chk("w1_mm1_addr", mm1_csr_addr, 14'h4);
        tick();
        chk("w1_mm2_we", mm2_csr_we, 1);
        chk("w1_mm1_we_clr", mm1_csr_we, 0);
        tick();
        chk("w1_wb_we", wb_csr_we, 1);
        chk("w1_lie_pre", csr_ecfg_lie_soft, 0);
        tick();
        chk("w1_lie", csr_ecfg_lie_soft, 2'b11);
        chk("w1_wb_we_clr", wb_csr_we, 0);

        set_ex(14'h5, 32'h1, 32'h1);
        tick(); ex_valid = 1'b0;
        tick(); tick();
        chk("w2_is_pre", csr_estat_is_soft, 0);
        chk("w2_pend_pre", soft_int_pending, 0);
        tick();
        chk("w2_is", csr_estat_is_soft, 2'b01);
        chk("w2_pend", soft_int_pending, 1);

        set_ex(14'h4, 32'h0, 32'h2);
        tick(); ex_valid = 1'b0;
        tick(); tick(); tick();
        chk("mask_lie", csr_ecfg_lie_soft, 2'b01);

        set_ex(14'h5, 32'h2, 32'h2); tick();
        set_ex(14'h4, 32'h2, 32'h3); tick();
        set_ex(14'h5, 32'h0, 32'h3); tick();
        ex_valid = 1'b0; wb_stall = 1'b1;
        #1 chk("stall_allowin", ex_allowin, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_wb_addr", wb_csr_addr, 14'h5);
            chk("stall_wb_wdata", wb_csr_wdata, 32'h2);
            chk("stall_mm2_addr", mm2_csr_addr, 14'h4);
            chk("stall_mm1_wmask", mm1_csr_wmask, 32'h3);
            chk("stall_is", csr_estat_is_soft, 2'b01);
        end
        wb_stall = 1'b0;
        tick();
        chk("stall_c1_is", csr_estat_is_soft, 2'b11);
        chk("stall_c1_wb_addr", wb_csr_addr, 14'h4);
        tick();
        chk("stall_c2_lie", csr_ecfg_lie_soft, 2'b10);
        tick();
        chk("stall_c3_is", csr_estat_is_soft, 2'b00);
        chk("stall_c3_pend", soft_int_pending, 0);

        set_ex(14'h5, 32'h2, 32'h3); tick();
        set_ex(14'h4, 32'h1, 32'h3); tick();
        set_ex(14'h4, 32'h3, 32'h3); tick();
        set_ex(14'h4, 32'h1, 32'h3); flush = 1'b1;
        #1 chk("flush_allowin", ex_allowin, 0);
        chk("flush_wb_we", wb_csr_we, 1);
        tick(); flush = 1'b0; ex_valid = 1'b0;
        chk("flush_mm1_we", mm1_csr_we, 0);
        chk("flush_mm2_we", mm2_csr_we, 0);
        chk("flush_wb_we_clr", wb_csr_we, 0);
        chk("flush_is", csr_estat_is_soft, 2'b00);
        repeat (4) tick();
        chk("flush_lie_after", csr_ecfg_lie_soft, 2'b10);
        chk("flush_is_after", csr_estat_is_soft, 2'b00);

        set_ex(14'h4, 32'h1, 32'h3); tick();
        set_ex(14'h5, 32'h1, 32'h3); tick();
        set_ex(14'h4, 32'h3, 32'h3); tick();
        #2 reset = 1'b1; ex_valid = 1'b0;
        #1 chk("arst_mm1_we", mm1_csr_we, 0);
        chk("arst_mm2_we", mm2_csr_we, 0);
        chk("arst_wb_we", wb_csr_we, 0);
        chk("arst_lie", csr_ecfg_lie_soft, 0);
        chk("arst_allowin", ex_allowin, 1);
        #1 reset = 1'b0;
        repeat (5) tick();
        chk("arst_lie_after", csr_ecfg_lie_soft, 0);
        chk("arst_is_after", csr_estat_is_soft, 0);
        chk("arst_pend_after", soft_int_pending, 0);

`ifdef CSR_HWI_EN
        hw_int = 8'h01;
        set_ex(14'h4, 32'h4, 32'h3FF); tick(); ex_valid = 1'b0;
        tick(); tick(); tick();
        chk("hwi_pend", soft_int_pending, 1);
        chk("hwi_lie_hw", csr_ecfg_lie_hw, 8'h01);
        set_ex(14'h5, 32'h3FC, 32'h3FF); tick(); ex_valid = 1'b0;
        tick(); tick(); tick();
        chk("hwi_is_soft", csr_estat_is_soft, 0);
        chk("hwi_pend_hold", soft_int_pending, 1);
        hw_int = 8'h00;
        tick();
        chk("hwi_pend_clr", soft_int_pending, 0);
`endif

        #1 reset = 1'b1;
        #1 reset = 1'b0;
        m_lie = '0; m_is = '0; m_pend = 1'b0;
        for (int k = 0; k < 3; k++) s[k] = '0;
        for (int i = 0; i < 1500; i++) begin
            ex_valid     = ($urandom % 3) != 0;
            ex_csr_addr  = addrs[$urandom % 3];
            ex_csr_we    = ($urandom % 5) != 0;
            ex_csr_wdata = $urandom;
            ex_csr_wmask = ($urandom % 2) ? 32'hFFFF_FFFF : $urandom;
            wb_stall     = ($urandom % 4) == 0;
            flush        = ($urandom % 20) == 0;
`ifdef CSR_HWI_EN
            hw_int       = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
`endif
            exp_allow = !flush && !(s[0].v && s[1].v && s[2].v && wb_stall);
            #1 chk("rnd_allowin", ex_allowin, exp_allow);
            model_step();
            tick();
            chk("rnd_mm1_we", mm1_csr_we, s[0].v & s[0].we);
            chk("rnd_wb_we", wb_csr_we, s[2].v & s[2].we);
            chk("rnd_lie", csr_ecfg_lie_soft, m_lie[1:0]);
            chk("rnd_is", csr_estat_is_soft, m_is[1:0]);
            chk("rnd_pend", soft_int_pending, m_pend);
            if (s[2].v) begin
                chk("rnd_wb_addr", wb_csr_addr, s[2].a);
                chk("rnd_wb_wdata", wb_csr_wdata, s[2].d);
                chk("rnd_wb_wmask", wb_csr_wmask, s[2].m);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
